// File: rtl/bomb_pkg.sv
// bomb_pkg: shared encodings for the defuse board.
// Game states, LFSR taps, BCD helpers and puzzle colours.
package bomb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    RUN      = 3'd2,
    DEFUSED  = 3'd3,
    EXPLODED = 3'd4
  } state_e;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DIGIT_W = 4;

  localparam logic [2:0] RED  = 3'b011;
  localparam logic [2:0] BLUE = 3'b110;
  localparam logic [2:0] GREN = 3'b101;
  localparam logic [2:0] YELW = 3'b001;
  localparam logic [2:0] DARK = 3'b111;

  // seconds (1..599) -> {min, tens, ones} BCD
  function automatic logic [11:0] sec_to_bcd(
    input int unsigned s
  );
    int unsigned m;
    int unsigned r;
    m = s / 60;
    r = s % 60;
    return {4'(m), 4'(r / 10), 4'(r % 10)};
  endfunction

endpackage

// File: rtl/bomb_if.sv
// bomb_if: game bus between sequencer and board.
// master = bomb_ctrl; slave = puzzle modules/display.
interface bomb_if
  import bomb_pkg::*;
#(
  parameter int N_MOD = 3
);
  logic               start_btn;
  logic [N_MOD-1:0]   done;
  logic [N_MOD-1:0]   wrong_tog;
  logic [11:0]        oseed;
  logic               mod;
  logic [1:0]         wrong_time;
  logic               mod_rst;
  logic [DIGIT_W-1:0] min_o;
  logic [DIGIT_W-1:0] sec_t;
  logic [DIGIT_W-1:0] sec_o;
  logic [2:0]         state;
  logic               beep;

  modport master (
    input  start_btn, done, wrong_tog,
    output oseed, mod, wrong_time, mod_rst,
    output min_o, sec_t, sec_o, state, beep
  );

  modport slave (
    output start_btn, done, wrong_tog,
    input  oseed, mod, wrong_time, mod_rst,
    input  min_o, sec_t, sec_o, state, beep
  );
endinterface

// File: rtl/bcd_countdown.sv
// bcd_countdown: m:ss BCD down-counter with load.
// in: load/load_val/tick; out: digits, zero_next (reads 0:01).
module bcd_countdown
  import bomb_pkg::*;
#(
  parameter logic [11:0] INIT = 12'h500
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               load,
  input  logic [11:0]        load_val,
  input  logic               tick,
  output logic [DIGIT_W-1:0] min_o,
  output logic [DIGIT_W-1:0] sec_t,
  output logic [DIGIT_W-1:0] sec_o,
  output logic               zero_next
);

  logic [3:0] min_q, min_d;
  logic [3:0] ten_q, ten_d;
  logic [3:0] one_q, one_d;

  always_comb begin
    min_d = min_q;
    ten_d = ten_q;
    one_d = one_q;
    if (load) begin
      {min_d, ten_d, one_d} = load_val;
    end else if (tick && {min_q, ten_q, one_q} != 12'h000) begin
      if (one_q != 4'd0) begin
        one_d = one_q - 4'd1;
      end else begin
        one_d = 4'd9;
        if (ten_q != 4'd0) begin
          ten_d = ten_q - 4'd1;
        end else begin
          ten_d = 4'd5;
          min_d = min_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      {min_q, ten_q, one_q} <= INIT;
    end else begin
      min_q <= min_d;
      ten_q <= ten_d;
      one_q <= one_d;
    end
  end

  assign min_o     = min_q;
  assign sec_t     = ten_q;
  assign sec_o     = one_q;
  assign zero_next = ({min_q, ten_q, one_q} == 12'h001);

endmodule

// File: rtl/bomb_ctrl.sv
// bomb_ctrl: defuse-board round sequencer (FSM, LFSR,
// second divider, strike detect); timer in bcd_countdown.
module bomb_ctrl
  import bomb_pkg::*;
#(
  parameter int          N_MOD     = 3,
  parameter int          TICK_DIV  = 1000,
  parameter int          START_SEC = 300,
  parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
  input logic   Clk,
  input logic   Rst,
  bomb_if.master io
);

  localparam int DIV_W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(TICK_DIV - 1);
  localparam logic [11:0] START_BCD =
    sec_to_bcd(START_SEC);

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               btn_q, btn_d;
  logic               btnp_q, btnp_d;
  logic [N_MOD-1:0]   tog_q, tog_d;
  logic [N_MOD-1:0]   togp_q, togp_d;
  logic [N_MOD-1:0]   done_q, done_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [11:0]        oseed_q, oseed_d;
  logic               mod_q, mod_d;
  logic [1:0]         wtime_q, wtime_d;
  logic               mod_rst_q, mod_rst_d;
  logic               beep_q, beep_d;

  logic start_edge, strike, all_done;
  logic tick, load, dec, zero_next;

  logic [DIGIT_W-1:0] min_w, ten_w, one_w;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    btn_d  = io.start_btn;
    btnp_d = btn_q;
    tog_d  = io.wrong_tog;
    togp_d = tog_q;
    done_d = io.done;

    start_edge = btn_q & ~btnp_q;
    // multiple toggles in one cycle are a single strike
    strike     = |(tog_q ^ togp_q);
    all_done   = &done_q;
    tick       = (state_q == RUN) && (div_q == DIV_MAX);

    state_d = state_q;
    div_d   = '0;
    oseed_d = oseed_q;
    mod_d   = mod_q;
    wtime_d = wtime_q;
    load    = 1'b0;
    dec     = 1'b0;

    unique case (state_q)
      IDLE: begin
        load = 1'b1;
        if (start_edge) state_d = ARM;
      end
      ARM: begin
        load    = 1'b1;
        oseed_d = lfsr_q[11:0];
        mod_d   = lfsr_q[15];
        wtime_d = 2'd0;
        state_d = RUN;
      end
      RUN: begin
        div_d = tick ? '0 : div_q + 1'b1;
        // defusing wins: the clock stops on that second
        dec   = tick & ~all_done;
        if (all_done) begin
          state_d = DEFUSED;
        end else if (strike && wtime_q == 2'd2) begin
          state_d = EXPLODED;
        end else begin
          if (strike) wtime_d = wtime_q + 2'd1;
          if (tick && zero_next) state_d = EXPLODED;
        end
      end
      DEFUSED, EXPLODED: begin
        if (start_edge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    mod_rst_d = (state_d == IDLE);
    beep_d    = tick && (state_d == RUN);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_INIT;
      btn_q     <= 1'b0;
      btnp_q    <= 1'b0;
      tog_q     <= '0;
      togp_q    <= '0;
      done_q    <= '0;
      div_q     <= '0;
      oseed_q   <= '0;
      mod_q     <= 1'b0;
      wtime_q   <= 2'd0;
      mod_rst_q <= 1'b1;
      beep_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      btn_q     <= btn_d;
      btnp_q    <= btnp_d;
      tog_q     <= tog_d;
      togp_q    <= togp_d;
      done_q    <= done_d;
      div_q     <= div_d;
      oseed_q   <= oseed_d;
      mod_q     <= mod_d;
      wtime_q   <= wtime_d;
      mod_rst_q <= mod_rst_d;
      beep_q    <= beep_d;
    end
  end

  bcd_countdown #(
    .INIT(START_BCD)
  ) u_timer (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (load),
    .load_val (START_BCD),
    .tick     (dec),
    .min_o    (min_w),
    .sec_t    (ten_w),
    .sec_o    (one_w),
    .zero_next(zero_next)
  );

  assign io.oseed      = oseed_q;
  assign io.mod        = mod_q;
  assign io.wrong_time = wtime_q;
  assign io.mod_rst    = mod_rst_q;
  assign io.min_o      = min_w;
  assign io.sec_t      = ten_w;
  assign io.sec_o      = one_w;
  assign io.state      = state_q;
  assign io.beep       = beep_q;

endmodule

// File: tb/tb_bomb_ctrl.sv
// tb_bomb_ctrl: directed bench for bomb_ctrl.
// Unit A runs 5:00 rounds, unit B runs 0:02 rounds.
module tb_bomb_ctrl;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  bomb_if #(.N_MOD(3)) ia ();
  bomb_if #(.N_MOD(3)) ib ();

  bomb_ctrl #(
    .N_MOD(3), .TICK_DIV(10), .START_SEC(300),
    .LFSR_INIT(16'hACE1)
  ) dut_a (.Clk(Clk), .Rst(Rst), .io(ia));

  bomb_ctrl #(
    .N_MOD(3), .TICK_DIV(10), .START_SEC(2),
    .LFSR_INIT(16'hACE1)
  ) dut_b (.Clk(Clk), .Rst(Rst), .io(ib));

  // reference LFSR: x^16+x^14+x^13+x^11, shift left
  logic [15:0] m_lfsr;
  always @(posedge Clk or posedge Rst) begin
    if (Rst) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[14:0],
      m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  function automatic logic [11:0] tim_a();
    return {ia.min_o, ia.sec_t, ia.sec_o};
  endfunction

  function automatic logic [11:0] tim_b();
    return {ib.min_o, ib.sec_t, ib.sec_o};
  endfunction

  logic [11:0] seed;
  logic        mb;
  int          beeps;

  initial begin
    ia.start_btn = 0; ia.done = '0; ia.wrong_tog = '0;
    ib.start_btn = 0; ib.done = '0; ib.wrong_tog = '0;
    cyc(3);
    Rst = 0;
    cyc(1);
    chk("rst_state", 16'(ia.state), 16'd0);
    chk("rst_modrst", 16'(ia.mod_rst), 16'd1);
    chk("rst_oseed", 16'(ia.oseed), 16'h000);
    chk("rst_mod", 16'(ia.mod), 16'd0);
    chk("rst_wtime", 16'(ia.wrong_time), 16'd0);
    chk("rst_beep", 16'(ia.beep), 16'd0);
    chk("rst_timer_a", 16'(tim_a()), 16'h500);
    chk("rst_timer_b", 16'(tim_b()), 16'h002);

    // ---- A: arm sequence
    ia.start_btn = 1;
    cyc(1);
    chk("a_k_state", 16'(ia.state), 16'd0);
    cyc(1);
    chk("a_arm_state", 16'(ia.state), 16'd1);
    chk("a_arm_modrst", 16'(ia.mod_rst), 16'd0);
    seed = m_lfsr[11:0];
    mb   = m_lfsr[15];
    cyc(1);
    chk("a_run_state", 16'(ia.state), 16'd2);
    chk("a_oseed", 16'(ia.oseed), 16'(seed));
    chk("a_mod", 16'(ia.mod), 16'(mb));
    chk("a_run_timer", 16'(tim_a()), 16'h500);
    ia.start_btn = 0;

    // ---- A: three seconds
    beeps = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (ia.beep) beeps++;
    end
    chk("a_timer_457", 16'(tim_a()), 16'h457);
    chk("a_beeps3", 16'(beeps), 16'd3);

    // ---- A: strikes
    ia.wrong_tog = 3'b001;
    cyc(1);
    chk("a_strike_lat", 16'(ia.wrong_time), 16'd0);
    cyc(1);
    chk("a_strike1", 16'(ia.wrong_time), 16'd1);
    ia.wrong_tog = 3'b111;
    cyc(2);
    chk("a_dual_strike", 16'(ia.wrong_time), 16'd2);
    chk("a_dual_state", 16'(ia.state), 16'd2);
    ia.wrong_tog = 3'b011;
    cyc(2);
    chk("a_boom_state", 16'(ia.state), 16'd4);
    chk("a_boom_wtime", 16'(ia.wrong_time), 16'd2);
    beeps = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (ia.beep) beeps++;
    end
    chk("a_frozen_timer", 16'(tim_a()), 16'h457);
    chk("a_frozen_beep", 16'(beeps), 16'd0);
    chk("a_frozen_state", 16'(ia.state), 16'd4);
    chk("a_frozen_seed", 16'(ia.oseed), 16'(seed));

    // ---- A: restart; toggles outside RUN are ignored
    ia.wrong_tog = 3'b010;
    ia.start_btn = 1;
    cyc(2);
    chk("a_idle_state", 16'(ia.state), 16'd0);
    chk("a_idle_modrst", 16'(ia.mod_rst), 16'd1);
    ia.start_btn = 0;
    ia.wrong_tog = 3'b101;
    cyc(2);
    chk("a_idle_timer", 16'(tim_a()), 16'h500);
    ia.start_btn = 1;
    cyc(2);
    chk("a_arm2_state", 16'(ia.state), 16'd1);
    seed = m_lfsr[11:0];
    mb   = m_lfsr[15];
    cyc(1);
    chk("a_oseed2", 16'(ia.oseed), 16'(seed));
    chk("a_mod2", 16'(ia.mod), 16'(mb));
    chk("a_wtime_clr", 16'(ia.wrong_time), 16'd0);
    ia.start_btn = 0;
    cyc(5);
    chk("a_no_phantom", 16'(ia.wrong_time), 16'd0);
    chk("a_run2_state", 16'(ia.state), 16'd2);

    // ---- async reset mid-round
    Rst = 1;
    #1;
    chk("mid_rst_state", 16'(ia.state), 16'd0);
    chk("mid_rst_modrst", 16'(ia.mod_rst), 16'd1);
    chk("mid_rst_timer", 16'(tim_a()), 16'h500);
    @(negedge Clk);
    Rst = 0;
    cyc(1);

    // ---- B: expiry at 0:02
    ib.start_btn = 1;
    cyc(2);
    chk("b_arm_state", 16'(ib.state), 16'd1);
    seed = m_lfsr[11:0];
    cyc(1);
    chk("b_run_state", 16'(ib.state), 16'd2);
    chk("b_oseed", 16'(ib.oseed), 16'(seed));
    chk("b_timer_002", 16'(tim_b()), 16'h002);
    ib.start_btn = 0;
    cyc(10);
    chk("b_timer_001", 16'(tim_b()), 16'h001);
    chk("b_beep1", 16'(ib.beep), 16'd1);
    cyc(9);
    chk("b_pre_exp_state", 16'(ib.state), 16'd2);
    cyc(1);
    chk("b_exp_timer", 16'(tim_b()), 16'h000);
    chk("b_exp_state", 16'(ib.state), 16'd4);

    // ---- B: done + strike + final tick together
    ib.start_btn = 1;
    cyc(2);
    chk("b_idle_state", 16'(ib.state), 16'd0);
    ib.start_btn = 0;
    cyc(2);
    ib.start_btn = 1;
    cyc(2);
    chk("b_arm2_state", 16'(ib.state), 16'd1);
    seed = m_lfsr[11:0];
    cyc(1);
    chk("b_oseed2", 16'(ib.oseed), 16'(seed));
    ib.start_btn = 0;
    ib.wrong_tog = 3'b100;
    cyc(2);
    chk("b_strike1", 16'(ib.wrong_time), 16'd1);
    cyc(16);
    ib.done = 3'b111;
    ib.wrong_tog = 3'b110;
    cyc(1);
    chk("b_pre_def_state", 16'(ib.state), 16'd2);
    chk("b_pre_def_timer", 16'(tim_b()), 16'h001);
    cyc(1);
    chk("b_def_state", 16'(ib.state), 16'd3);
    chk("b_def_wtime", 16'(ib.wrong_time), 16'd1);
    chk("b_def_timer", 16'(tim_b()), 16'h001);
    cyc(5);
    chk("b_def_hold", 16'(ib.state), 16'd3);
    chk("b_def_beep", 16'(ib.beep), 16'd0);
    ib.start_btn = 1;
    cyc(2);
    chk("b_back_idle", 16'(ib.state), 16'd0);
    chk("b_back_modrst", 16'(ib.mod_rst), 16'd1);
    ib.start_btn = 0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
